iob_timer_reader: RTL and testbench

Bus initiator that drives the timer peripheral's native valid/ready register interface from the other end. On a command it either clears the counter through the soft-reset register or samples it with a HIGH-then-LOW read pair, returning a coherent 64-bit timestamp. It sits between a local requester (trace unit, profiler, DMA tagger) and the timer's CPU port, replacing a CPU-driven read sequence.

---
 rtl/iob_timer_reader_if.sv | 25 ++
 rtl/iob_timer_reader.sv | 142 ++++++++++++++
 tb/tb_iob_timer_reader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_timer_reader_if.sv
// Command side and timer register bus of iob_timer_reader, bundled as one interface.
// The master modport is the reader; the slave modport is the requester/timer environment.
interface iob_timer_reader_if;
    logic        cmd_valid;
    logic        cmd_op;
    logic        cmd_ready;
    logic [63:0] ts;
    logic        done;
    logic        err;
    logic        m_valid;
    logic [1:0]  m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    modport master (
        input  cmd_valid, cmd_op, m_ready, m_rdata,
        output cmd_ready, ts, done, err, m_valid, m_addr, m_wdata
    );

    modport slave (
        output cmd_valid, cmd_op, m_ready, m_rdata,
        input  cmd_ready, ts, done, err, m_valid, m_addr, m_wdata
    );
endinterface

// File: rtl/iob_timer_reader.sv
// Bus initiator for the timer's valid/ready register port: clears the counter or
// samples it as a coherent 64-bit {HIGH, LOW} timestamp, with a per-request timeout.
module iob_timer_reader #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst,
    iob_timer_reader_if.master bus
);

    typedef enum logic [2:0] {StIdle, StRdHi, StGap, StRdLo, StClr} state_e;

    localparam logic [1:0]  AddrReset = 2'd0;
    localparam logic [1:0]  AddrHigh  = 2'd1;
    localparam logic [1:0]  AddrLow   = 2'd2;
    localparam logic [15:0] WaitLast  = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        m_valid_q, m_valid_d;
    logic [1:0]  m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] hold_q, hold_d;
    logic [63:0] ts_q, ts_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] wait_q, wait_d;
    logic        waiting;
    logic        timed_out;

    // m_valid_q is high for the whole of RD_HI, RD_LO and CLR, so this only counts there.
    assign waiting   = m_valid_q && !bus.m_ready;
    assign timed_out = waiting && (wait_q == WaitLast);

    always_comb begin
        state_d   = state_q;
        m_valid_d = 1'b0;
        m_addr_d  = m_addr_q;
        m_wdata_d = '0;
        hold_d    = hold_q;
        ts_d      = ts_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        wait_d    = waiting ? wait_q + 16'd1 : wait_q;

        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    wait_d    = '0;
                    m_valid_d = 1'b1;
                    if (bus.cmd_op) begin
                        state_d   = StClr;
                        m_addr_d  = AddrReset;
                        m_wdata_d = 32'h1;
                    end else begin
                        state_d  = StRdHi;
                        m_addr_d = AddrHigh;
                    end
                end
            end
            StRdHi: begin
                if (bus.m_ready) begin
                    hold_d  = bus.m_rdata;
                    state_d = StGap;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    m_valid_d = 1'b1;
                end
            end
            StGap: begin
                // Lets the timer's late ready for the HIGH read drain before LOW is requested.
                state_d   = StRdLo;
                m_valid_d = 1'b1;
                m_addr_d  = AddrLow;
                wait_d    = '0;
            end
            StRdLo: begin
                if (bus.m_ready) begin
                    ts_d    = {hold_q, bus.m_rdata};
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    m_valid_d = 1'b1;
                end
            end
            StClr: begin
                if (bus.m_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    m_valid_d = 1'b1;
                    m_wdata_d = 32'h1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            hold_q    <= '0;
            ts_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            hold_q    <= hold_d;
            ts_q      <= ts_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.ts        = ts_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;

    a_done_err_excl: assert property (@(posedge clk) disable iff (rst) !(done_q && err_q));
    a_valid_drops: assert property (@(posedge clk) disable iff (rst)
        (m_valid_q && bus.m_ready) |=> !m_valid_q);

endmodule

// File: tb/tb_iob_timer_reader.sv
// Self-checking bench for iob_timer_reader: timer model, vector table, scoreboard queue.
module tb_iob_timer_reader;

    localparam int unsigned Timeout = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iob_timer_reader_if bus ();

    iob_timer_reader #(
        .TIMEOUT(Timeout)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string name, input bit ok, input logic [63:0] act,
                           input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Timer model: free-running counter, HIGH read snapshots LOW, ready one cycle
    // after valid (or hi_lat cycles for HIGH), stale ready while valid is held.
    bit          t_stuck = 1'b0;
    int          t_hi_lat = 1;
    bit          t_fixed = 1'b0;
    logic [31:0] t_fix_hi = '0, t_fix_lo = '0;
    logic        t_ready;
    logic [31:0] t_rdata, t_snap, t_hi;
    logic [63:0] tcnt;
    int          t_wait;

    assign bus.m_ready = t_ready;
    assign bus.m_rdata = t_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_ready <= 1'b0;
            t_rdata <= '0;
            t_snap  <= '0;
            t_hi    <= '0;
            tcnt    <= '0;
            t_wait  <= 0;
        end else begin
            tcnt <= tcnt + 64'd1;
            if (t_ready) begin
                t_ready <= bus.m_valid;
                t_wait  <= 0;
            end else if (bus.m_valid && !t_stuck) begin
                if (t_wait + 1 >= ((bus.m_addr == 2'd1) ? t_hi_lat : 1)) begin
                    t_ready <= 1'b1;
                    t_wait  <= 0;
                    case (bus.m_addr)
                        2'd0: begin
                            if (bus.m_wdata[0]) tcnt <= '0;
                            t_rdata <= '0;
                        end
                        2'd1: begin
                            t_rdata <= t_fixed ? t_fix_hi : tcnt[63:32];
                            t_snap  <= tcnt[31:0];
                            t_hi    <= tcnt[63:32];
                        end
                        default: t_rdata <= t_fixed ? t_fix_lo : t_snap;
                    endcase
                end else begin
                    t_wait <= t_wait + 1;
                end
            end else begin
                t_ready <= 1'b0;
                t_wait  <= 0;
            end
        end
    end

    typedef struct {
        logic        op;
        logic        err;
        int          lat;
        logic        fixed;
        logic [63:0] fix_ts;
        int          acc;
    } exp_t;

    typedef struct {
        logic        op;
        logic        stuck;
        int          hi_lat;
        logic        fixed;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [63:0] exp_ts;
    logic [63:0] model_ts = '0;
    logic        cur_err = 1'b0, cur_fixed = 1'b0;
    int          cur_lat = 6;
    logic [63:0] cur_fix_ts = '0;
    bit          prev_ack = 1'b0, burst = 1'b0;
    int          run_len = 0, max_run = 0, clr_run = 0, last_done = -1, burst_dones = 0;

    // Scoreboard: push on accept, pop and compare on done/err.
    always @(negedge clk) begin
        if (rst) begin
            prev_ack = 1'b0;
            run_len  = 0;
            clr_run  = 0;
        end else begin
            if (prev_ack) compare("valid_drop_after_ack", !bus.m_valid, 64'(bus.m_valid), 64'd0);
            prev_ack = bus.m_valid && bus.m_ready;
            if (bus.m_valid) begin
                compare("wdata_by_addr", bus.m_wdata == ((bus.m_addr == 2'd0) ? 32'h1 : 32'h0),
                        64'(bus.m_wdata), 64'(bus.m_addr == 2'd0));
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (bus.m_addr == 2'd0) clr_run++;
            end else begin
                run_len = 0;
            end
            if (bus.done || bus.err) begin
                compare("done_err_exclusive", !(bus.done && bus.err), 64'({bus.done, bus.err}),
                        64'd2);
                if (exp_q.size() == 0) begin
                    compare("unexpected_completion", 1'b0, 64'({bus.done, bus.err}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    compare("outcome_err", bus.err == e.err, 64'(bus.err), 64'(e.err));
                    compare("latency", (cyc - e.acc) == e.lat, 64'(cyc - e.acc), 64'(e.lat));
                    if (e.err || e.op) exp_ts = model_ts;
                    else if (e.fixed) exp_ts = e.fix_ts;
                    else exp_ts = {t_hi, t_snap};
                    compare("ts", bus.ts == exp_ts, bus.ts, exp_ts);
                    if (!e.err && !e.op) model_ts = exp_ts;
                    if (bus.err) compare("m_valid_after_err", !bus.m_valid, 64'(bus.m_valid), 64'd0);
                    if (!e.err && e.op) compare("clr_cycles", clr_run == 2, 64'(clr_run), 64'd2);
                    if (burst && bus.done) begin
                        if (last_done >= 0)
                            compare("burst_interval", (cyc - last_done) == 6,
                                    64'(cyc - last_done), 64'd6);
                        last_done = cyc;
                        burst_dones++;
                    end
                end
                clr_run = 0;
            end
            if (bus.cmd_valid && bus.cmd_ready)
                exp_q.push_back('{op: bus.cmd_op, err: cur_err, lat: cur_lat, fixed: cur_fixed,
                                  fix_ts: cur_fix_ts, acc: cyc});
        end
    end

    task automatic issue(input logic op);
        int n = 0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) compare("cmd_accept", 1'b0, 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        compare("completion_in_time", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        t_stuck    = v.stuck;
        t_hi_lat   = v.hi_lat;
        t_fixed    = v.fixed;
        t_fix_hi   = v.hi;
        t_fix_lo   = v.lo;
        cur_err    = v.exp_err;
        cur_lat    = v.exp_lat;
        cur_fixed  = v.fixed;
        cur_fix_ts = {v.hi, v.lo};
        issue(v.op);
        wait_done();
    endtask

    vec_t vecs[7];

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b0, 1, 1'b0, 32'h0, 32'h0, 1'b0, 6};
        vecs[1] = '{1'b1, 1'b0, 1, 1'b0, 32'h0, 32'h0, 1'b0, 3};
        vecs[2] = '{1'b0, 1'b0, 3, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0, 8};
        vecs[3] = '{1'b0, 1'b1, 1, 1'b0, 32'h0, 32'h0, 1'b1, int'(Timeout) + 1};
        vecs[4] = '{1'b0, 1'b0, 1, 1'b1, 32'hA5A50F0F, 32'h5A5AF0F0, 1'b0, 6};
        vecs[5] = '{1'b1, 1'b1, 1, 1'b0, 32'h0, 32'h0, 1'b1, int'(Timeout) + 1};
        vecs[6] = '{1'b1, 1'b0, 1, 1'b0, 32'h0, 32'h0, 1'b0, 3};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compare("rst_cmd_ready", bus.cmd_ready == 1'b1, 64'(bus.cmd_ready), 64'd1);
        compare("rst_m_valid", bus.m_valid == 1'b0, 64'(bus.m_valid), 64'd0);
        compare("rst_m_addr", bus.m_addr == 2'd0, 64'(bus.m_addr), 64'd0);
        compare("rst_m_wdata", bus.m_wdata == 32'd0, 64'(bus.m_wdata), 64'd0);
        compare("rst_ts", bus.ts == 64'd0, bus.ts, 64'd0);
        compare("rst_done", bus.done == 1'b0, 64'(bus.done), 64'd0);
        compare("rst_err", bus.err == 1'b0, 64'(bus.err), 64'd0);
        rst = 1'b0;

        // Real-timer sample after 100 idle cycles.
        repeat (100) @(negedge clk);
        run_vec(vecs[0]);
        compare("ts_high_zero", bus.ts[63:32] == 32'd0, 64'(bus.ts[63:32]), 64'd0);

        // Clear, wait 10 cycles, sample: counter restarted.
        run_vec(vecs[1]);
        repeat (10) @(negedge clk);
        run_vec(vecs[0]);
        compare("ts_small_after_clear", bus.ts < 64'd20, bus.ts, 64'd20);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset while in RD_LO.
        run_vec(vecs[4]);
        t_stuck = 1'b0; t_hi_lat = 1; t_fixed = 1'b0;
        cur_err = 1'b0; cur_lat = 6; cur_fixed = 1'b0;
        issue(1'b0);
        n = 0;
        while (!(bus.m_valid && bus.m_addr == 2'd2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        compare("reach_rd_lo", bus.m_valid && bus.m_addr == 2'd2, 64'(bus.m_addr), 64'd2);
        #2 rst = 1'b1;
        #1;
        compare("async_valid_drop", bus.m_valid == 1'b0, 64'(bus.m_valid), 64'd0);
        compare("no_done_on_reset", bus.done == 1'b0, 64'(bus.done), 64'd0);
        compare("ts_cleared_on_reset", bus.ts == 64'd0, bus.ts, 64'd0);
        compare("cmd_ready_on_reset", bus.cmd_ready == 1'b1, 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        exp_q.delete();
        model_ts = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_vec(vecs[0]);

        // Back-to-back samples with cmd_valid held high.
        last_done = -1; burst_dones = 0; max_run = 0; burst = 1'b1;
        cur_err = 1'b0; cur_lat = 6; cur_fixed = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_done();
        burst = 1'b0;
        compare("burst_count", burst_dones >= 6, 64'(burst_dones), 64'd6);
        compare("max_valid_run", max_run == 2, 64'(max_run), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the test finished");
        $fatal(1);
    end

endmodule
